// File: rtl/seg7_scan_scheduler_pkg.sv
// Shared types and seven-segment pattern constants for the digit scan scheduler.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_scan_scheduler_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0] hex;
        logic       dp;
    } digit_t;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;

endpackage

// File: rtl/seg7_scan_scheduler_if.sv
// Writer-side digit update port: valid/ready handshake plus commit strobe.
interface seg7_scan_scheduler_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_idx;
    logic [3:0] wr_hex;
    logic       wr_dp;
    logic       commit;

    modport master (
        output wr_valid, wr_idx, wr_hex, wr_dp, commit,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_idx, wr_hex, wr_dp, commit,
        output wr_ready
    );
endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit hex to seven-segment decoder (0-9, A, b, C, d, E, F).
module seg7_hex_decoder
    import seg7_scan_scheduler_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_comb begin
        seg = '0;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = '0;
        endcase
    end
endmodule

// File: rtl/seg7_scan_scheduler.sv
// Multiplexes NUM_DIGITS hex digits onto one segment bus with blanking gaps;
// shadow digit values are published atomically at the frame boundary.
module seg7_scan_scheduler
    import seg7_scan_scheduler_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 1000,
    parameter int BLANK      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_scheduler_if.slave  wr,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  frame_start
);
    localparam int TMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = $clog2(NUM_DIGITS);

    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK - 1);
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    state_t          state;
    logic [TW-1:0]   timer;
    logic [IW-1:0]   idx;
    logic            commit_pending;
    digit_t          shadow [NUM_DIGITS];
    digit_t          active [NUM_DIGITS];

    logic            wr_fire;
    logic            wr_idx_ok;
    digit_t          next_ent;
    logic [6:0]      next_seg;

    assign wr.wr_ready = ~commit_pending;
    assign wr_fire     = wr.wr_valid & ~commit_pending;
    assign wr_idx_ok   = ({29'd0, wr.wr_idx} < 32'(NUM_DIGITS));

    // Entering digit 0 with a publish pending must already show the shadow value.
    always_comb begin
        next_ent = active[idx];
        if (commit_pending && (idx == '0))
            next_ent = shadow[idx];
    end

    seg7_hex_decoder u_dec (
        .hex (next_ent.hex),
        .seg (next_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_BLANK;
            timer          <= '0;
            idx            <= '0;
            commit_pending <= 1'b0;
            seg_out        <= '0;
            dp_out         <= 1'b0;
            dig_sel        <= '0;
            frame_start    <= 1'b0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            frame_start <= 1'b0;

            if (wr_fire && wr_idx_ok)
                shadow[wr.wr_idx[IW-1:0]] <= '{hex: wr.wr_hex, dp: wr.wr_dp};

            // A commit landing on the boundary edge sets pending after the
            // publish check, so it waits for the following boundary.
            if (wr.commit && !commit_pending)
                commit_pending <= 1'b1;

            case (state)
                S_BLANK: begin
                    if (timer == BLANK_LAST) begin
                        state   <= S_SHOW;
                        timer   <= '0;
                        dig_sel <= NUM_DIGITS'(1) << idx;
                        seg_out <= next_seg;
                        dp_out  <= next_ent.dp;
                        if (idx == '0) begin
                            frame_start <= 1'b1;
                            if (commit_pending) begin
                                active         <= shadow;
                                commit_pending <= 1'b0;
                            end
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_SHOW: begin
                    if (timer == DWELL_LAST) begin
                        state   <= S_BLANK;
                        timer   <= '0;
                        dig_sel <= '0;
                        seg_out <= '0;
                        dp_out  <= 1'b0;
                        idx     <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= S_BLANK;
            endcase
        end
    end
endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Directed bench for seg7_scan_scheduler (4 digits, DWELL=4, BLANK=2, 24-cycle frame);
// published digit sets are queued at commit and popped at the frame boundary.
module tb_seg7_scan_scheduler;
    localparam int FRAME = 24;
    localparam int SLOT  = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [3:0] dig_sel;
    logic       frame_start;

    seg7_scan_scheduler_if bus ();

    seg7_scan_scheduler #(
        .NUM_DIGITS (4),
        .DWELL      (4),
        .BLANK      (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr          (bus),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .dig_sel     (dig_sel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][3:0] hex;
        logic [3:0]      dp;
    } snap_t;

    int              checks   = 0;
    int              failures = 0;
    int              cyc      = 0;
    int              last_fs  = -1;
    logic [3:0][3:0] s_hex, a_hex;
    logic [3:0]      s_dp, a_dp;
    bit              m_pending;
    snap_t           pub_q [$];

    function automatic logic [6:0] dec(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int pos, d, w;
        bit lit;
        pos = cyc % FRAME;
        d   = pos / SLOT;
        w   = pos % SLOT;
        lit = (w >= 2);
        chk("dig_sel",     32'(dig_sel),     lit ? (32'd1 << d) : 32'd0);
        chk("seg_out",     32'(seg_out),     lit ? 32'(dec(a_hex[d])) : 32'd0);
        chk("dp_out",      32'(dp_out),      lit ? 32'(a_dp[d]) : 32'd0);
        chk("frame_start", 32'(frame_start), (lit && d == 0 && w == 2) ? 32'd1 : 32'd0);
        chk("wr_ready",    32'(bus.wr_ready), m_pending ? 32'd0 : 32'd1);
        if (frame_start === 1'b1) begin
            if (last_fs >= 0)
                chk("fs_period", 32'(cyc - last_fs), 32'(FRAME));
            last_fs = cyc;
        end
    endtask

    // Apply this cycle's inputs to the model, advance one clock, then compare.
    task automatic step();
        int    nxt;
        bit    pn;
        snap_t sn;
        if (rst === 1'b0) begin
            s_hex = '0; s_dp = '0; a_hex = '0; a_dp = '0;
            m_pending = 1'b0;
            pub_q.delete();
            nxt = 0;
            last_fs = -1;
        end else begin
            nxt = cyc + 1;
            pn  = m_pending;
            if ((nxt % FRAME == 2) && m_pending) begin
                if (pub_q.size() > 0) begin
                    sn = pub_q.pop_front();
                    a_hex = sn.hex;
                    a_dp  = sn.dp;
                end
                pn = 1'b0;
            end
            if (bus.wr_valid && !m_pending && bus.wr_idx < 3'd4) begin
                s_hex[bus.wr_idx[1:0]] = bus.wr_hex;
                s_dp[bus.wr_idx[1:0]]  = bus.wr_dp;
            end
            if (bus.commit && !m_pending) begin
                pn = 1'b1;
                pub_q.push_back('{hex: s_hex, dp: s_dp});
            end
            m_pending = pn;
        end
        @(posedge clk);
        #1;
        cyc = nxt;
        check_all();
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < FRAME && (cyc % FRAME) != target; i++)
            step();
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_idx   = '0;
        bus.wr_hex   = '0;
        bus.wr_dp    = 1'b0;
        bus.commit   = 1'b0;

        // 1: reset, release, first frame
        step();
        step();
        rst = 1'b1;
        step();
        step();
        chk("t1_first_sel", 32'(dig_sel), 32'h1);
        chk("t1_first_seg", 32'(seg_out), 32'h3F);
        chk("t1_first_fs",  32'(frame_start), 32'h1);
        run_until(8);
        chk("t1_dig1_sel",  32'(dig_sel), 32'h2);

        // 2: two writes then commit mid-frame
        bus.wr_valid = 1'b1; bus.wr_idx = 3'd0; bus.wr_hex = 4'h8; bus.wr_dp = 1'b1;
        step();
        bus.wr_idx = 3'd3; bus.wr_hex = 4'hF; bus.wr_dp = 1'b0;
        step();
        bus.wr_valid = 1'b0;
        bus.commit   = 1'b1;
        step();
        bus.commit   = 1'b0;
        chk("t2_ready_low", 32'(bus.wr_ready), 32'h0);
        run_until(2);
        chk("t2_dig0_seg",  32'(seg_out), 32'h7F);
        chk("t2_dig0_dp",   32'(dp_out), 32'h1);
        chk("t2_ready_back", 32'(bus.wr_ready), 32'h1);
        run_until(20);
        chk("t2_dig3_seg",  32'(seg_out), 32'h71);

        // 3: write+commit together, then a write held while stalled
        bus.wr_valid = 1'b1; bus.wr_idx = 3'd2; bus.wr_hex = 4'hA; bus.wr_dp = 1'b0;
        bus.commit   = 1'b1;
        step();
        bus.commit   = 1'b0;
        bus.wr_idx = 3'd1; bus.wr_hex = 4'h5; bus.wr_dp = 1'b1;
        run_until(2);
        step();
        step();
        bus.wr_valid = 1'b0;
        bus.commit   = 1'b1;
        step();
        bus.commit   = 1'b0;
        run_until(2);
        run_until(8);
        chk("t3_dig1_seg",  32'(seg_out), 32'h6D);
        chk("t3_dig1_dp",   32'(dp_out), 32'h1);
        run_until(14);
        chk("t3_dig2_seg",  32'(seg_out), 32'h77);

        // 4: out-of-range index is accepted and dropped
        chk("t4_ready", 32'(bus.wr_ready), 32'h1);
        bus.wr_valid = 1'b1; bus.wr_idx = 3'd5; bus.wr_hex = 4'h3; bus.wr_dp = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        bus.commit   = 1'b1;
        step();
        bus.commit   = 1'b0;
        run_until(2);
        run_until(8);

        // 4b: commit on the boundary edge publishes one frame later
        bus.wr_valid = 1'b1; bus.wr_idx = 3'd1; bus.wr_hex = 4'hC; bus.wr_dp = 1'b0;
        step();
        bus.wr_valid = 1'b0;
        run_until(1);
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
        chk("t4b_pending", 32'(bus.wr_ready), 32'h0);
        run_until(8);
        chk("t4b_old_seg", 32'(seg_out), 32'h6D);
        run_until(2);
        run_until(8);
        chk("t4b_new_seg", 32'(seg_out), 32'h39);

        // 5: reset during digit 2 dwell
        run_until(14);
        rst = 1'b0;
        step();
        chk("t5_sel_zero", 32'(dig_sel), 32'h0);
        chk("t5_seg_zero", 32'(seg_out), 32'h0);
        rst = 1'b1;
        run_until(2);
        chk("t5_seg_clear", 32'(seg_out), 32'h3F);
        chk("t5_fs",        32'(frame_start), 32'h1);

        // 6: three free-running frames
        for (int i = 0; i < 3 * FRAME; i++)
            step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
